// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the I-cache, D-cache and external-memory sides of the line-memory
//   arbiter so they travel as one port.
//
//   Handshake: a cache raises its request (i_mem_read, d_mem_read or
//   d_mem_write) as a level and holds the address/data stable until it sees
//   its x_mem_ready pulse. The pulse is high for exactly one cycle and
//   completes the transaction. The arbiter holds mem_read/mem_write and
//   mem_addr/mem_wdata stable until memory answers with a one-cycle
//   mem_ready. mem_rdata is only meaningful in the cycle mem_ready is high.
//
//   Modports:
//     slave  - the arbiter's view (requests in, data/ready out)
//     master - the environment's view (caches plus external memory)
//
//   arb_state is a debug view of the arbiter FSM:
//   0 = IDLE, 1 = BUSY_I, 2 = BUSY_D, 3 = DONE.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [1:0]        arb_state;

    modport slave (
        input  i_mem_read, i_mem_addr,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output arb_state
    );

    modport master (
        output i_mem_read, i_mem_addr,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  arb_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 128-bit line-memory port between the I-cache (read only) and
//   the D-cache (read / write-back). One line transaction is in flight at a
//   time; the granted cache gets its read data and a one-cycle ready pulse.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - mem_port_arbiter_if.slave: cache request/response signals,
//              external memory strobes/data, debug FSM state
//
//   Parameters:
//     ADDR_W       - line address width
//     DATA_W       - line data width
//     D_FIXED_PRIO - 1: D-cache wins ties; 0: round-robin between I and D
//
//   Every output comes straight from a flop.
module mem_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int D_FIXED_PRIO = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = D was granted last
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic d_req, i_req, grant_d, grant_i;

    assign d_req = bus.d_mem_read | bus.d_mem_write;
    assign i_req = bus.i_mem_read;

    // On a tie D wins under fixed priority; under round-robin D wins only if
    // I had the previous grant.
    assign grant_d = d_req & (~i_req | (D_FIXED_PRIO != 0) | ~last_grant_q);
    assign grant_i = i_req & ~grant_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    // Next-state logic. DONE never arbitrates, so a cache that drops its
    // request on seeing ready cannot be re-granted a stale request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = BUSY_D;
                else if (grant_i) state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values
    always_comb begin
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // Read and write together is a write-back.
                    last_grant_d = 1'b1;
                    mem_addr_d   = bus.d_mem_addr;
                    mem_wdata_d  = bus.d_mem_wdata;
                    mem_write_d  = bus.d_mem_write;
                    mem_read_d   = ~bus.d_mem_write;
                end else if (grant_i) begin
                    last_grant_d = 1'b0;
                    mem_addr_d   = bus.i_mem_addr;
                    mem_write_d  = 1'b0;
                    mem_read_d   = 1'b1;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = bus.mem_rdata;
                    i_ready_d   = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) d_rdata_d = bus.mem_rdata;
                    d_ready_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_mem_rdata = i_rdata_q;
    assign bus.i_mem_ready = i_ready_q;
    assign bus.d_mem_rdata = d_rdata_q;
    assign bus.d_mem_ready = d_ready_q;
    assign bus.arb_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters share the same cache-side stimulus: dut_a uses fixed D
//   priority, dut_b uses round-robin. Each has its own line-memory model
//   that answers a strobe after mem_lat cycles with data derived from the
//   address. Expected read data, strobes and grant orders come from a
//   transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] JUNK = {4{32'h0BAD_F00D}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_FIXED_PRIO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_FIXED_PRIO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [DW-1:0] d_mem_wdata = '0;

  assign bus_a.i_mem_read  = i_mem_read;
  assign bus_a.i_mem_addr  = i_mem_addr;
  assign bus_a.d_mem_read  = d_mem_read;
  assign bus_a.d_mem_write = d_mem_write;
  assign bus_a.d_mem_addr  = d_mem_addr;
  assign bus_a.d_mem_wdata = d_mem_wdata;
  assign bus_b.i_mem_read  = i_mem_read;
  assign bus_b.i_mem_addr  = i_mem_addr;
  assign bus_b.d_mem_read  = d_mem_read;
  assign bus_b.d_mem_write = d_mem_write;
  assign bus_b.d_mem_addr  = d_mem_addr;
  assign bus_b.d_mem_wdata = d_mem_wdata;

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return {a, 4'h3, ~a, 4'hC, a, 4'h9, a[23:0], 8'hA5};
  endfunction

  int   mem_lat = 5;
  logic force_rdy_a = 1'b0;
  logic rdy_a, rdy_b;
  int   cnt_a, cnt_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_a <= 1'b0; cnt_a <= 0;
    end else if (rdy_a) begin
      rdy_a <= 1'b0;
    end else if (cnt_a != 0) begin
      if (cnt_a == 1) rdy_a <= 1'b1;
      cnt_a <= cnt_a - 1;
    end else if (bus_a.mem_read || bus_a.mem_write) begin
      cnt_a <= mem_lat;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_b <= 1'b0; cnt_b <= 0;
    end else if (rdy_b) begin
      rdy_b <= 1'b0;
    end else if (cnt_b != 0) begin
      if (cnt_b == 1) rdy_b <= 1'b1;
      cnt_b <= cnt_b - 1;
    end else if (bus_b.mem_read || bus_b.mem_write) begin
      cnt_b <= mem_lat;
    end
  end

  assign bus_a.mem_ready = rdy_a | force_rdy_a;
  assign bus_a.mem_rdata = rdy_a ? line_data(bus_a.mem_addr) : JUNK;
  assign bus_b.mem_ready = rdy_b;
  assign bus_b.mem_rdata = rdy_b ? line_data(bus_b.mem_addr) : JUNK;

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] grant_a_q[$];
  logic [AW-1:0] grant_b_q[$];
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   rdy_pulses_a = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Log each new grant (rising strobe) with its address.
  always @(negedge clk) begin
    if (rst_n && (bus_a.mem_read || bus_a.mem_write) && !prev_a) grant_a_q.push_back(bus_a.mem_addr);
    if (rst_n && (bus_b.mem_read || bus_b.mem_write) && !prev_b) grant_b_q.push_back(bus_b.mem_addr);
    prev_a <= rst_n && (bus_a.mem_read || bus_a.mem_write);
    prev_b <= rst_n && (bus_b.mem_read || bus_b.mem_write);
    if (bus_a.i_mem_ready || bus_a.d_mem_ready) rdy_pulses_a <= rdy_pulses_a + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic drop_reqs();
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;
    d_mem_write = 1'b0;
  endtask

  task automatic apply_reset();
    drop_reqs();
    force_rdy_a = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  task automatic settle();
    drop_reqs();
    repeat (30) @(negedge clk);
  endtask

  // One transaction on dut_a from a single requester, checked end to end.
  task automatic run_txn(input bit is_d, input bit rd, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int lat, input bit drop_early);
    bit exp_wr;
    bit got;
    bit held_ok;
    exp_wr = is_d & wr;
    mem_lat = lat;
    if (is_d) begin
      d_mem_read = rd; d_mem_write = wr; d_mem_addr = addr; d_mem_wdata = wdata;
      i_mem_addr = AW'($urandom);
    end else begin
      i_mem_read = 1'b1; i_mem_addr = addr;
      d_mem_addr = AW'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.mem_write !== exp_wr || bus_a.mem_read !== !exp_wr) begin
      n_fail++;
      $display("FAIL grant_strobe: rd/wr=%b%b expected %b%b", bus_a.mem_read, bus_a.mem_write, !exp_wr, exp_wr);
    end
    n_checks++;
    if (bus_a.mem_addr !== addr) begin
      n_fail++;
      $display("FAIL grant_addr: got %h expected %h", bus_a.mem_addr, addr);
    end
    if (exp_wr) begin
      n_checks++;
      if (bus_a.mem_wdata !== wdata) begin
        n_fail++;
        $display("FAIL grant_wdata: got %h expected %h", bus_a.mem_wdata, wdata);
      end
    end
    if (drop_early) drop_reqs();
    got = 1'b0;
    held_ok = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if ((is_d ? bus_a.d_mem_ready : bus_a.i_mem_ready) === 1'b1) got = 1'b1;
      else if (bus_a.mem_addr !== addr || bus_a.mem_write !== exp_wr || bus_a.mem_read !== !exp_wr ||
               bus_a.i_mem_ready !== 1'b0 || bus_a.d_mem_ready !== 1'b0) held_ok = 1'b0;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: got no ready expected ready within 64 cycles (is_d=%0d)", is_d);
    end
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL busy_hold: got changing bus/early ready expected stable strobes addr %h", addr);
    end
    if (!exp_wr) begin
      if (is_d) exp_d_rdata = line_data(addr);
      else      exp_i_rdata = line_data(addr);
    end
    n_checks++;
    if (bus_a.mem_read !== 1'b0 || bus_a.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL done_strobe: rd/wr=%b%b expected 00", bus_a.mem_read, bus_a.mem_write);
    end
    n_checks++;
    if (bus_a.i_mem_rdata !== exp_i_rdata) begin
      n_fail++;
      $display("FAIL i_rdata: got %h expected %h", bus_a.i_mem_rdata, exp_i_rdata);
    end
    n_checks++;
    if (bus_a.d_mem_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL d_rdata: got %h expected %h", bus_a.d_mem_rdata, exp_d_rdata);
    end
    n_checks++;
    if ((is_d ? bus_a.i_mem_ready : bus_a.d_mem_ready) !== 1'b0) begin
      n_fail++;
      $display("FAIL other_ready: got 1 expected 0 (is_d=%0d)", is_d);
    end
    drop_reqs();
    @(negedge clk);
    n_checks++;
    if (bus_a.i_mem_ready !== 1'b0 || bus_a.d_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_width: i/d ready=%b%b expected 00", bus_a.i_mem_ready, bus_a.d_mem_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus_a.mem_read, bus_a.mem_write, bus_a.i_mem_ready, bus_a.d_mem_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus_a.mem_read, bus_a.mem_write, bus_a.i_mem_ready, bus_a.d_mem_ready});
    end
    n_checks++;
    if (bus_a.mem_addr !== '0 || bus_a.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0", bus_a.mem_addr, bus_a.mem_wdata);
    end
    n_checks++;
    if (bus_a.i_mem_rdata !== '0 || bus_a.d_mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h / %h expected 0", bus_a.i_mem_rdata, bus_a.d_mem_rdata);
    end
    n_checks++;
    if (bus_a.arb_state !== 2'd0 || bus_b.arb_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%0d expected 0", bus_a.arb_state, bus_b.arb_state);
    end
  endtask

  task automatic test_i_read();
    run_txn(1'b0, 1'b1, 1'b0, 28'h0000010, '0, 5, 1'b0);
  endtask

  task automatic test_d_write();
    run_txn(1'b1, 1'b1, 1'b0, 28'h0000040, '0, 3, 1'b0);
    run_txn(1'b1, 1'b0, 1'b1, 28'h00000F0, 128'hDEAD0123_456789AB_CDEF0123_4567BEEF, 5, 1'b0);
  endtask

  task automatic test_fixed_prio();
    bit got;
    settle();
    grant_a_q.delete();
    mem_lat = 4;
    i_mem_read = 1'b1; i_mem_addr = 28'h10;
    d_mem_read = 1'b1; d_mem_addr = 28'h20;
    @(negedge clk);
    n_checks++;
    if (bus_a.mem_read !== 1'b1 || bus_a.mem_addr !== 28'h20) begin
      n_fail++;
      $display("FAIL prio_first: got rd=%b addr %h expected rd=1 addr 20", bus_a.mem_read, bus_a.mem_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus_a.d_mem_ready === 1'b1) got = 1'b1;
    end
    d_mem_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_a.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: got rd=%b expected 0 one cycle after d ready", bus_a.mem_read);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.mem_read !== 1'b1 || bus_a.mem_addr !== 28'h10) begin
      n_fail++;
      $display("FAIL prio_second: got rd=%b addr %h expected rd=1 addr 10 two cycles after d ready",
               bus_a.mem_read, bus_a.mem_addr);
    end
    for (int c = 0; c < 64 && bus_a.i_mem_ready !== 1'b1; c++) @(negedge clk);
    n_checks++;
    if (!got || bus_a.i_mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_ready: got d=%0d i=%b expected both completions", got, bus_a.i_mem_ready);
    end
    drop_reqs();
    exp_d_rdata = line_data(28'h20);
    exp_i_rdata = line_data(28'h10);
    n_checks++;
    if (bus_a.i_mem_rdata !== exp_i_rdata || bus_a.d_mem_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL prio_rdata: got %h / %h expected %h / %h", bus_a.i_mem_rdata, bus_a.d_mem_rdata,
               exp_i_rdata, exp_d_rdata);
    end
    exp_q = '{28'h20, 28'h10};
    n_checks++;
    if (grant_a_q.size() != 2 || grant_a_q[0] !== exp_q[0] || grant_a_q[1] !== exp_q[1]) begin
      n_fail++;
      $display("FAIL prio_order: got %0d grants first %h expected 2 grants 20,10",
               grant_a_q.size(), (grant_a_q.size() > 0) ? grant_a_q[0] : 28'h0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    grant_a_q.delete();
    grant_b_q.delete();
    mem_lat = 3;
    i_mem_read = 1'b1; i_mem_addr = 28'h10;
    d_mem_read = 1'b1; d_mem_addr = 28'h20;
    for (int c = 0; c < 300 && grant_b_q.size() < 4; c++) @(negedge clk);
    drop_reqs();
    exp_q = '{28'h20, 28'h10, 28'h20, 28'h10};
    n_checks++;
    if (grant_b_q.size() < 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants expected 4", grant_b_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (grant_b_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got %h expected %h", k, grant_b_q[k], exp_q[k]);
        end
      end
    end
    // Fixed priority starves I while D keeps requesting.
    n_checks++;
    if (grant_a_q.size() < 3 || grant_a_q[0] !== 28'h20 || grant_a_q[1] !== 28'h20 || grant_a_q[2] !== 28'h20) begin
      n_fail++;
      $display("FAIL fixed_starve: got %0d grants first %h expected >=3 grants all 20",
               grant_a_q.size(), (grant_a_q.size() > 0) ? grant_a_q[0] : 28'h0);
    end
    settle();
    exp_d_rdata = line_data(28'h20);
    n_checks++;
    if (bus_a.d_mem_rdata !== exp_d_rdata || bus_a.i_mem_rdata !== exp_i_rdata) begin
      n_fail++;
      $display("FAIL rr_rdata: got %h / %h expected %h / %h", bus_a.i_mem_rdata, bus_a.d_mem_rdata,
               exp_i_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    settle();
    mem_lat = 20;
    d_mem_write = 1'b1; d_mem_read = 1'b0; d_mem_addr = 28'h00000F0;
    d_mem_wdata = 128'hDEAD0123_456789AB_CDEF0123_4567BEEF;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_a.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got wr=%b expected 1 before reset", bus_a.mem_write);
    end
    pulses = rdy_pulses_a;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.mem_read, bus_a.mem_write, bus_a.i_mem_ready, bus_a.d_mem_ready, bus_a.mem_addr,
         bus_a.mem_wdata, bus_a.i_mem_rdata, bus_a.d_mem_rdata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got rd/wr=%b%b addr %h wdata %h expected all 0",
               bus_a.mem_read, bus_a.mem_write, bus_a.mem_addr, bus_a.mem_wdata);
    end
    drop_reqs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdy_pulses_a != pulses || bus_a.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abandon: got %0d ready pulses wr=%b expected 0 pulses wr=0",
               rdy_pulses_a - pulses, bus_a.mem_write);
    end
    run_txn(1'b0, 1'b1, 1'b0, 28'h0000033, '0, 3, 1'b0);
  endtask

  task automatic test_rw_spurious();
    settle();
    force_rdy_a = 1'b1;
    @(negedge clk);
    force_rdy_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_a.mem_read, bus_a.mem_write, bus_a.i_mem_ready, bus_a.d_mem_ready} !== 4'b0 ||
        bus_a.d_mem_rdata !== exp_d_rdata || bus_a.i_mem_rdata !== exp_i_rdata) begin
      n_fail++;
      $display("FAIL spurious_ready: got flags %b expected 0000 and rdata unchanged",
               {bus_a.mem_read, bus_a.mem_write, bus_a.i_mem_ready, bus_a.d_mem_ready});
    end
    run_txn(1'b1, 1'b1, 1'b1, 28'h0ABCDE0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 1'b0);
  endtask

  task automatic test_random();
    bit is_d, rd, wr;
    int op;
    settle();
    for (int n = 0; n < 24; n++) begin
      is_d = bit'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      rd = !is_d || op != 1;
      wr = is_d && op != 0;
      run_txn(is_d, rd, wr, AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(1, 8)), bit'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_fixed_prio();
    test_round_robin();
    test_reset_mid();
    test_rw_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow 128-bit line-memory port between the instruction cache (read-only) and the data cache (read/write).
- This allows the RISC-V pipeline, I-cache and D-cache to run against a single external memory.
- Sits between the two cache mem-side interfaces and the external memory.
- Serialises line transactions and returns read data and a one-cycle ready pulse to the granted cache.

Parameters:
ADDR_W, 28, line address width (byte address bits 31:4)
DATA_W, 128, line data width
D_FIXED_PRIO, 1, 1 = D-cache always wins ties; 0 = round-robin between I and D

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_mem_read  input  1  I-cache line read request (level, held until i_mem_ready)
i_mem_addr  input  ADDR_W  I-cache line address
i_mem_rdata  output  DATA_W  line data returned to I-cache
i_mem_ready  output  1  one-cycle completion pulse to I-cache
d_mem_read  input  1  D-cache line read request
d_mem_write  input  1  D-cache line write-back request
d_mem_addr  input  ADDR_W  D-cache line address
d_mem_wdata  input  DATA_W  D-cache write-back data
d_mem_rdata  output  DATA_W  line data returned to D-cache
d_mem_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  external memory read strobe
mem_write  output  1  external memory write strobe
mem_addr  output  ADDR_W  external memory line address
mem_wdata  output  DATA_W  external memory write data
mem_rdata  input  DATA_W  external memory read data
mem_ready  input  1  external memory completion, single cycle

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; last_grant = I.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- Request definitions:
  - d_req = d_mem_read | d_mem_write.
  - i_req = i_mem_read.
- IDLE, arbitration:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both with D_FIXED_PRIO=1: grant D.
  - Both with D_FIXED_PRIO=0: grant the requester opposite last_grant.
  - On grant: update last_grant; latch address, operation and wdata (D only) into mem_addr/mem_wdata/mem_read/mem_write.
  - Go to BUSY_I or BUSY_D.
  - Latency: request sampled at edge N; memory strobe visible from cycle N+1.
- d_mem_read and d_mem_write both high: treated as a write (mem_write=1, mem_read=0).
- BUSY_x:
  - mem_* outputs held constant.
  - Requester inputs are ignored; deasserting the request does not abort the transaction.
  - On mem_ready=1 at an edge, all of the following happen and the FSM goes to DONE:
    - mem_read and mem_write clear.
    - For a read, mem_rdata is captured into x_mem_rdata.
    - x_mem_ready is set.
- DONE:
  - Granted x_mem_ready is high for exactly this one cycle; then it clears and the FSM goes to IDLE.
  - No arbitration in DONE. This guarantees a requester that drops its request on seeing ready is never re-granted a stale request.
- Writes: d_mem_rdata is not updated; it holds its previous value.
- x_mem_rdata holds its last value until the next read completion for that requester.
- mem_ready in IDLE or DONE is ignored.
- Minimum spacing between consecutive grants is 2 cycles after completion (DONE + IDLE).
- Never more than one memory strobe active; mem_read & mem_write is never 1.
- Reset mid-transaction: asynchronously returns to the reset values. The outstanding memory transaction is abandoned without a ready pulse.

Test Plan:
- Reset, then I read of addr 0x0000010 alone; memory returns 0x…A5 after 5 cycles -> mem_read=1, mem_addr=0x0000010 one cycle after request; i_mem_rdata=0x…A5; i_mem_ready high exactly 1 cycle; d_mem_ready stays 0.
- D write-back of addr 0x00000F0, wdata 0xDEAD…BEEF -> mem_write=1 with that addr/wdata held stable until mem_ready; d_mem_ready pulses once; d_mem_rdata unchanged.
- D_FIXED_PRIO=1, I read 0x10 and D read 0x20 asserted in the same cycle -> D served first (mem_addr=0x20), then I (mem_addr=0x10). I is granted 2 cycles after d_mem_ready.
- D_FIXED_PRIO=0, both requesters continuously re-request for 4 transactions -> grant order D,I,D,I. No requester is starved.
- Assert rst_n=0 while BUSY_D with mem_write=1 -> all outputs 0 immediately, without waiting for a clock edge; no ready pulse; after release, a new I request is served normally.
- d_mem_read and d_mem_write both high, plus a spurious mem_ready in IDLE -> spurious mem_ready ignored; transaction issued as a write (mem_read=0).
